// File: rtl/load_pkg.sv
// Shared definitions for the load aligner: funct3 codes, FSM states and
// access-width helpers used by both the controller and the extractor.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    CAP0,
    RD1,
    CAP1,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } width_sel;

  function automatic logic funct3_legal(input logic [2:0] funct3);
    return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

  function automatic width_sel width_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  // True when the access runs past the end of the first word.
  function automatic logic spans_word(input logic [2:0] funct3, input logic [1:0] offset);
    case (width_of(funct3))
      HALF:    return offset == 2'd3;
      WORD:    return offset != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane shifter: moves the addressed bytes of {word1, word0}
// down to bit 0 and sign- or zero-extends them according to funct3.
module load_extract
  import load_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [63:0] shifted;
  logic        sext;
  logic        unused_hi;

  assign shifted   = data >> {offset, 3'b000};
  assign sext      = ~funct3[2];
  assign unused_hi = ^shifted[63:32];

  always_comb begin
    result = shifted[31:0];
    case (width_of(funct3))
      BYTE:    result = {{24{sext & shifted[7]}}, shifted[7:0]};
      HALF:    result = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: result = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/load_aligner.sv
// Multi-cycle load-data aligner: one or two word reads per load, result over valid/ready.
// Define LOAD_ALIGNER_SPLIT_EN to support loads that span two words; otherwise they error.
module load_aligner
  import load_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        req_fire;
  logic        req_bad;
  logic [63:0] ext_data;
  logic [31:0] ext_result;

  assign req_fire = req_valid && (state_q == IDLE);

`ifdef LOAD_ALIGNER_SPLIT_EN
  logic [31:0] word0_q;
  logic        cur_spans;

  assign cur_spans = spans_word(f3_q, addr_q[1:0]);
  assign req_bad   = !funct3_legal(req_funct3);
  assign ext_data  = (state_q == CAP1) ? {mem_rdata, word0_q} : {32'h0, mem_rdata};
`else
  // Without the second read, spanning loads are rejected before touching memory.
  assign req_bad  = !funct3_legal(req_funct3) || spans_word(req_funct3, req_addr[1:0]);
  assign ext_data = {32'h0, mem_rdata};
`endif

  load_extract u_extract (
    .data   (ext_data),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .result (ext_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = req_bad ? RESP : RD0;
      end
      RD0:  state_d = CAP0;
`ifdef LOAD_ALIGNER_SPLIT_EN
      CAP0: state_d = cur_spans ? RD1 : RESP;
      RD1:  state_d = CAP1;
      CAP1: state_d = RESP;
`else
      CAP0: state_d = RESP;
`endif
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef LOAD_ALIGNER_SPLIT_EN
      word0_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        addr_q <= req_addr;
        f3_q   <= req_funct3;
        data_q <= '0;
        err_q  <= req_bad;
      end
`ifdef LOAD_ALIGNER_SPLIT_EN
      if (state_q == CAP0) begin
        word0_q <= mem_rdata;
        if (!cur_spans) data_q <= ext_result;
      end
      if (state_q == CAP1) data_q <= ext_result;
`else
      if (state_q == CAP0) data_q <= ext_result;
`endif
    end
  end

  // Handshake outputs are gated by reset so an aborted request never shows up.
  assign req_ready = !rst && (state_q == IDLE);
  assign mem_rd_en = !rst && ((state_q == RD0) || (state_q == RD1));
  assign rsp_valid = !rst && (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

  always_comb begin
    mem_addr = '0;
    if (!rst) begin
      case (state_q)
        RD0:     mem_addr = {addr_q[31:2], 2'b00};
`ifdef LOAD_ALIGNER_SPLIT_EN
        RD1:     mem_addr = {addr_q[31:2] + 30'd1, 2'b00};
`endif
        default: mem_addr = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_aligner.sv
// Self-checking bench for load_aligner: directed loads from a small memory image
// plus randomized loads checked against a byte-level reference model.
module tb_load_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd_log[$];

`ifdef LOAD_ALIGNER_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  load_aligner dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h8899_AABB;
      32'h0000_0104: return 32'h1122_3344;
      32'hFFFF_FFFC: return 32'hDEAD_BEEF;
      32'h0000_0000: return 32'h00C0_FFEE;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Synchronous memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem_word(mem_addr);
      rd_log.push_back(mem_addr);
    end
  end

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  task automatic refLoad(input logic [31:0] addr, input logic [2:0] f3,
                         output logic [31:0] data, output logic err,
                         output int n_reads, output int lat);
    int n;
    logic legal;
    logic span;
    logic [31:0] ba;
    n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
            (f3 == 3'b100) || (f3 == 3'b101);
    span  = (int'(addr[1:0]) + n) > 4;
    err   = !legal || (span && !SPLIT);
    data  = 32'h0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        ba   = addr + 32'(i);
        data = data | (32'(byte_at(ba)) << (8 * i));
      end
      if (!f3[2] && n < 4 && data[8*n-1]) data = data | (32'hFFFF_FFFF << (8 * n));
    end
    n_reads = err ? 0 : (span ? 2 : 1);
    lat     = err ? 1 : (span ? 5 : 3);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic waitIdle();
    int w = 0;
    while (!req_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  // One full load: issue, measure latency, check data/reads, optional backpressure, handshake.
  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] f3, input int hold);
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_reads;
    int          exp_lat;
    int          lat;
    int          nrd;
    refLoad(addr, f3, exp_data, exp_err, exp_reads, exp_lat);
    waitIdle();
    if (!req_ready) begin
      checkOutput("req_ready_wait", {31'h0, req_ready}, 32'h1);
      return;
    end
    rd_log.delete();
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    rsp_ready  = (hold == 0);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      checkOutput("rsp_timeout", {31'h0, rsp_valid}, 32'h1);
      rsp_ready = 1'b0;
      return;
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_data", rsp_data, exp_data);
    checkOutput("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
    nrd = rd_log.size();
    checkOutput("read_count", 32'(nrd), 32'(exp_reads));
    if (nrd >= 1 && exp_reads >= 1) checkOutput("read0_addr", rd_log[0], {addr[31:2], 2'b00});
    if (nrd >= 2 && exp_reads >= 2) checkOutput("read1_addr", rd_log[1], {addr[31:2], 2'b00} + 32'd4);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", {31'h0, rsp_valid}, 32'h1);
      checkOutput("hold_data", rsp_data, exp_data);
      checkOutput("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    if (hold > 0) checkOutput("hold_no_reads", 32'(rd_log.size()), 32'(nrd));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("post_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("post_req_ready", {31'h0, req_ready}, 32'h1);
  endtask

  // Reset lands while the load sits in CAP0; its response must never appear.
  task automatic applyResetMidLoad();
    int seen = 0;
    waitIdle();
    rsp_ready  = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0100;
    req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_mem_rd_en", {31'h0, mem_rd_en}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || mem_rd_en) seen++;
    end
    checkOutput("aborted_no_activity", 32'(seen), 32'h0);
    rsp_ready = 1'b0;
    applyStimulus(32'h0000_0100, 3'b000, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h0);
    checkOutput("reset_rd_en", {31'h0, mem_rd_en}, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset_rsp_data", rsp_data, 32'h0);
    checkOutput("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("after_reset_ready", {31'h0, req_ready}, 32'h1);

    applyStimulus(32'h0000_0101, 3'b000, 0);
    applyStimulus(32'h0000_0103, 3'b100, 0);
    applyStimulus(32'h0000_0102, 3'b001, 0);
    applyStimulus(32'h0000_0102, 3'b101, 0);
    applyStimulus(32'h0000_0100, 3'b010, 0);
    applyStimulus(32'h0000_0102, 3'b010, 0);
    applyStimulus(32'h0000_0103, 3'b001, 0);
    applyStimulus(32'hFFFF_FFFE, 3'b010, 0);
    applyStimulus(32'h0000_0100, 3'b011, 0);
    applyStimulus(32'h0000_0100, 3'b111, 0);
    applyStimulus(32'h0000_0101, 3'b000, 4);
    applyStimulus(32'h0000_0102, 3'b010, 4);

    applyResetMidLoad();

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'h0000_0100 + 32'($urandom_range(0, 15));
        1:       a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: a = $urandom;
      endcase
      applyStimulus(a, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
